// File: rtl/branch_compare_serial_if.sv
// Request/result bundle for the serial branch comparator.
//   start     : request a compare (honoured only when the unit is idle or finishing)
//   a, b      : operands rs1 / rs2
//   is_signed : 1 = two's-complement ordering, 0 = unsigned
//   funct3    : branch condition selector
//   busy      : high while nibbles are being processed
//   done      : one-cycle pulse when gt/lt/eq/taken are fresh
//   gt/lt/eq  : magnitude relation of a to b
//   taken     : branch condition result
interface branch_compare_serial_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic [2:0]       funct3;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             taken;

  // Issuing stage side
  modport master (
    output start, a, b, is_signed, funct3,
    input  busy, done, gt, lt, eq, taken
  );

  // Comparator side
  modport slave (
    input  start, a, b, is_signed, funct3,
    output busy, done, gt, lt, eq, taken
  );
endinterface

// File: rtl/branch_compare_serial.sv
// Serial magnitude comparator for the branch unit and SLT/SLTU path.
// One 4-bit slice is reused for WIDTH/4 cycles, least-significant nibble first; the slice's
// gt/lt/eq outputs are registered and cascaded into the next nibble, so a more-significant
// nibble that differs always overrides whatever the lower nibbles decided.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : branch_compare_serial_if slave (start/a/b/is_signed/funct3 in,
//           busy/done/gt/lt/eq/taken out)
module branch_compare_serial #(
  parameter int unsigned WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_compare_serial_if.slave bus
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IdxLast = IDXW'(NIB - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [2:0]       f3_q, f3_d;
  logic             cas_gt_q, cas_gt_d;
  logic             cas_lt_q, cas_lt_d;
  logic             cas_eq_q, cas_eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             taken_q, taken_d;

  logic [3:0] nib_a, nib_b;
  logic       s_gt, s_lt, s_eq;
  logic       last;

  function automatic logic taken_of(input logic [2:0] f3, input logic e, input logic l);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = e;
      3'b001:  t = ~e;
      3'b100:  t = l;
      3'b101:  t = ~l;
      3'b110:  t = l;
      3'b111:  t = ~l;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign last = (idx_q == IdxLast);

  // Nibble select and the 4-bit cascaded comparator slice
  always_comb begin
    nib_a = a_q[{idx_q, 2'b00} +: 4];
    nib_b = b_q[{idx_q, 2'b00} +: 4];
    // Flipping the sign bit on the top nibble turns two's-complement order into unsigned order
    if (sgn_q && last) begin
      nib_a[3] = ~nib_a[3];
      nib_b[3] = ~nib_b[3];
    end
    s_gt = (nib_a > nib_b) | ((nib_a == nib_b) & cas_gt_q);
    s_lt = (nib_a < nib_b) | ((nib_a == nib_b) & cas_lt_q);
    s_eq = (nib_a == nib_b) & cas_eq_q;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    f3_d     = f3_q;
    cas_gt_d = cas_gt_q;
    cas_lt_d = cas_lt_q;
    cas_eq_d = cas_eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    taken_d  = taken_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          sgn_d    = bus.is_signed;
          f3_d     = bus.funct3;
          cas_gt_d = 1'b0;
          cas_lt_d = 1'b0;
          cas_eq_d = 1'b1;
          idx_d    = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        cas_gt_d = s_gt;
        cas_lt_d = s_lt;
        cas_eq_d = s_eq;
        if (last) begin
          // Outputs only ever see the final cascade result
          gt_d    = s_gt;
          lt_d    = s_lt;
          eq_d    = s_eq;
          taken_d = taken_of(f3_q, s_eq, s_lt);
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDXW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      f3_q     <= 3'b000;
      cas_gt_q <= 1'b0;
      cas_lt_q <= 1'b0;
      cas_eq_q <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      f3_q     <= f3_d;
      cas_gt_q <= cas_gt_d;
      cas_lt_q <= cas_lt_d;
      cas_eq_q <= cas_eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      taken_q  <= taken_d;
    end
  end

  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.gt    = gt_q;
  assign bus.lt    = lt_q;
  assign bus.eq    = eq_q;
  assign bus.taken = taken_q;

endmodule

// File: tb/tb_branch_compare_serial.sv
// Bench for branch_compare_serial: arithmetic reference model checked every cycle, plus
// directed cases with literal expectations.
module tb_branch_compare_serial;

  localparam int unsigned NIB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  branch_compare_serial_if #(.WIDTH(32)) bus ();

  branch_compare_serial #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: {gt, lt, eq, taken} straight from arithmetic comparison
  function automatic logic [3:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic [2:0] f3);
    logic g, l, e, t;
    if (s) begin
      g = ($signed(a) > $signed(b));
      l = ($signed(a) < $signed(b));
    end else begin
      g = (a > b);
      l = (a < b);
    end
    e = (a == b);
    case (f3)
      3'b000:  t = e;
      3'b001:  t = !e;
      3'b100, 3'b110: t = l;
      3'b101, 3'b111: t = !l;
      default: t = 1'b0;
    endcase
    return {g, l, e, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level model: an accepted request completes NIB edges later
  int         run_left;
  logic [3:0] pend;
  logic       m_busy, m_done, m_gt, m_lt, m_eq, m_taken;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_left <= 0;
      pend     <= 4'b0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_gt     <= 1'b0;
      m_lt     <= 1'b0;
      m_eq     <= 1'b0;
      m_taken  <= 1'b0;
    end else if (run_left != 0) begin
      run_left <= run_left - 1;
      m_busy   <= (run_left > 1);
      m_done   <= (run_left == 1);
      if (run_left == 1) {m_gt, m_lt, m_eq, m_taken} <= pend;
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        pend     <= ref_result(bus.a, bus.b, bus.is_signed, bus.funct3);
        run_left <= NIB;
        m_busy   <= 1'b1;
      end else begin
        m_busy   <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cycle_outputs", {26'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.taken},
        {26'd0, m_busy, m_done, m_gt, m_lt, m_eq, m_taken});
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [2:0] f3);
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.funct3    = f3;
  endtask

  // Issue one request from idle, check latency, busy length and literal flags
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [2:0] f3, input logic [3:0] exp);
    int lat;
    int bc;
    drive(a, b, s, f3);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    bc  = 0;
    while (lat < 20) begin
      if (bus.busy) bc++;
      @(posedge clk);
      #1 lat++;
      if (bus.done) break;
    end
    chk({name, "_latency"}, lat, 8);
    chk({name, "_busy_cycles"}, bc, 8);
    chk({name, "_flags"}, {bus.gt, bus.lt, bus.eq, bus.taken}, exp);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ra, rb;
  logic        seen_done;
  int          gap;

  initial begin
    bus.start = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 3'b000);

    // Pin the reference model itself
    chk("ref_unsigned_gt", ref_result(32'hFFFF_FFFF, 32'h1, 1'b0, 3'b110), 4'b1000);
    chk("ref_signed_lt", ref_result(32'hFFFF_FFFF, 32'h1, 1'b1, 3'b100), 4'b0101);
    chk("ref_f3_010", ref_result(32'h0, 32'h0, 1'b0, 3'b010), 4'b0010);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_outputs", {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.taken}, 6'b0);

    // Reset in the middle of a compare
    drive(32'd5, 32'd3, 1'b0, 3'b000);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midrun_reset_outputs", {bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.taken}, 6'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("no_done_after_abort", seen_done, 1'b0);

    run_op("after_reset_5v3", 32'd5, 32'd3, 1'b0, 3'b001, 4'b1001);
    run_op("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 3'b000, 4'b0011);
    run_op("ff_vs_1_unsigned", 32'hFFFF_FFFF, 32'h1, 1'b0, 3'b110, 4'b1000);
    run_op("ff_vs_1_signed", 32'hFFFF_FFFF, 32'h1, 1'b1, 3'b100, 4'b0101);
    run_op("low_nibble", 32'h8000_0011, 32'h8000_0010, 1'b1, 3'b101, 4'b1001);
    run_op("upper_dominates", 32'h10, 32'h01, 1'b0, 3'b000, 4'b1000);
    run_op("f3_010", 32'h0, 32'h0, 1'b0, 3'b010, 4'b0010);

    // start during RUN is ignored; start in DONE chains without an idle gap
    drive(32'd7, 32'd9, 1'b0, 3'b110);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 drive(32'd9, 32'd7, 1'b0, 3'b111);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    gap = 0;
    while (!bus.done && gap < 20) begin
      @(posedge clk);
      #1 gap++;
    end
    chk("ignored_start_done", bus.done, 1'b1);
    chk("ignored_start_flags", {bus.gt, bus.lt, bus.eq, bus.taken}, 4'b0101);
    drive(32'h0, 32'h0, 1'b0, 3'b010);
    bus.start = 1'b1;
    gap = 0;
    do begin
      @(posedge clk);
      #1 gap++;
      bus.start = 1'b0;
    end while (!bus.done && gap < 20);
    chk("back_to_back_gap", gap, 9);
    chk("back_to_back_flags", {bus.gt, bus.lt, bus.eq, bus.taken}, 4'b0010);
    @(posedge clk);
    #1;

    // Random traffic; the per-cycle compare does the checking
    for (int c = 0; c < 4000; c++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ra;
        2: begin
          rb = ra;
          rb[4 * $urandom_range(0, 7) +: 4] = 4'($urandom_range(0, 15));
        end
        default: rb = ra ^ 32'h8000_0000;
      endcase
      drive(ra, rb, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      bus.start = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
